// File: rtl/nvram_pkg.sv
// Shared types and constants for the CMOS nvram upload path.
package nvram_pkg;

  typedef enum logic [2:0] {
    NV_IDLE,
    NV_GRANT,
    NV_ISSUE_LO,
    NV_ISSUE_HI,
    NV_COLLECT,
    NV_DONE
  } nv_state_t;

  localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;
  localparam logic [7:0] NV_FILL          = 8'hFF;

endpackage

// File: rtl/nvram_upload.sv
// HPS upload responder: fetches two 4-bit CMOS cells per ioctl read and returns them packed.
//
// state       | meaning
// IDLE        | waiting for ioctl_rd while selected
// GRANT       | waiting for ram_gnt
// ISSUE_LO    | ram_rd on the even (low) cell
// ISSUE_HI    | ram_rd on the odd (high) cell
// COLLECT     | waiting for the high cell to come back, then returns the byte
// DONE        | out-of-range read: return fill byte
module nvram_upload
  import nvram_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] NV_INDEX = NV_INDEX_DEFAULT,
  parameter int         RAM_LAT  = 1
) (
  input  logic              clk_sys_i,
  input  logic              reset_n_i,
  input  logic              ioctl_upload_i,
  input  logic [7:0]        ioctl_index_i,
  input  logic [24:0]       ioctl_addr_i,
  input  logic              ioctl_rd_i,
  output logic [7:0]        ioctl_din_o,
  output logic              ioctl_wait_o,
  output logic              ram_req_o,
  input  logic              ram_gnt_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_o,
  input  logic [3:0]        ram_q_i,
  output logic              err_o
);

  nv_state_t           state_q, state_d;
  logic [ADDR_W-2:0]   a_q, a_d;
  logic [7:0]          din_q, din_d;
  logic                wait_q, wait_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rd_q, rd_d;
  logic                err_q, err_d;
  logic [3:0]          lo_q, lo_d;
  logic [RAM_LAT-1:0]  vld_q, vld_d;
  logic [RAM_LAT-1:0]  tag_q, tag_d;

  logic sel;
  logic oor;
  logic cap;
  logic cap_hi;

  assign sel    = ioctl_upload_i && (ioctl_index_i == NV_INDEX);
  assign oor    = |ioctl_addr_i[24:ADDR_W-1];
  assign cap    = vld_q[RAM_LAT-1];
  assign cap_hi = cap && tag_q[RAM_LAT-1];

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= NV_IDLE;
      a_q     <= '0;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      raddr_q <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= 4'h0;
      vld_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      raddr_q <= raddr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    din_d   = din_q;
    wait_d  = wait_q;
    req_d   = sel;
    raddr_d = raddr_q;
    rd_d    = 1'b0;
    err_d   = err_q;
    lo_d    = lo_q;

    // Each issued read travels down the pipe tagged with its cell parity.
    vld_d[0] = rd_q;
    tag_d[0] = raddr_q[0];
    for (int i = 1; i < RAM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    if (cap && !tag_q[RAM_LAT-1]) lo_d = ram_q_i;

    if (ioctl_rd_i && sel && (state_q != NV_IDLE)) err_d = 1'b1;

    case (state_q)
      NV_IDLE: begin
        if (ioctl_rd_i && sel) begin
          a_d     = ioctl_addr_i[ADDR_W-2:0];
          wait_d  = 1'b1;
          state_d = oor ? NV_DONE : NV_GRANT;
        end
      end
      NV_GRANT: begin
        if (ram_gnt_i) begin
          state_d = NV_ISSUE_LO;
          rd_d    = 1'b1;
          raddr_d = {a_q, 1'b0};
        end
      end
      NV_ISSUE_LO: begin
        state_d = NV_ISSUE_HI;
        rd_d    = 1'b1;
        raddr_d = {a_q, 1'b1};
      end
      NV_ISSUE_HI: begin
        state_d = NV_COLLECT;
      end
      NV_COLLECT: begin
        // High cell lands on the same edge the byte is returned.
        if (cap_hi) begin
          din_d   = {ram_q_i, lo_q};
          wait_d  = 1'b0;
          state_d = NV_IDLE;
        end
      end
      NV_DONE: begin
        din_d   = NV_FILL;
        wait_d  = 1'b0;
        state_d = NV_IDLE;
      end
      default: state_d = NV_IDLE;
    endcase

    // Losing the session abandons the transfer and any reads still in flight.
    if ((state_q != NV_IDLE) && !sel) begin
      state_d = NV_IDLE;
      wait_d  = 1'b0;
      rd_d    = 1'b0;
      din_d   = din_q;
      vld_d   = '0;
    end
  end

  assign ioctl_din_o  = din_q;
  assign ioctl_wait_o = wait_q;
  assign ram_req_o    = req_q;
  assign ram_addr_o   = raddr_q;
  assign ram_rd_o     = rd_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_nvram_upload.sv
// Self-checking bench for nvram_upload with a behavioural CMOS RAM and grant model.
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ram_req;
  logic        ram_gnt;
  logic [7:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_q;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] mem [256];
  logic [7:0] rd_log [$];
  logic [7:0] sb_q [$];
  logic [7:0] last_din;

  bit gnt_hold = 1'b1;
  int gnt_delay = 0;
  int gnt_cnt = 0;

  nvram_upload #(.ADDR_W(8), .NV_INDEX(8'd4), .RAM_LAT(1)) dut (
    .clk_sys_i      (clk_sys),
    .reset_n_i      (reset_n),
    .ioctl_upload_i (ioctl_upload),
    .ioctl_index_i  (ioctl_index),
    .ioctl_addr_i   (ioctl_addr),
    .ioctl_rd_i     (ioctl_rd),
    .ioctl_din_o    (ioctl_din),
    .ioctl_wait_o   (ioctl_wait),
    .ram_req_o      (ram_req),
    .ram_gnt_i      (ram_gnt),
    .ram_addr_o     (ram_addr),
    .ram_rd_o       (ram_rd),
    .ram_q_i        (ram_q),
    .err_o          (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk_sys) begin
    if (ram_rd === 1'b1) begin
      ram_q <= mem[ram_addr];
      rd_log.push_back(ram_addr);
    end
  end

  // Grant either held permanently or raised gnt_delay cycles after ram_req rises.
  always @(posedge clk_sys) begin
    #1;
    if (gnt_hold) ram_gnt = 1'b1;
    else if (ram_req !== 1'b1) begin
      gnt_cnt = 0;
      ram_gnt = 1'b0;
    end else begin
      gnt_cnt++;
      ram_gnt = (gnt_cnt > gnt_delay);
    end
  end

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    logic [7:0] lo_a;
    if (a >= 25'h80) return 8'hFF;
    lo_a = {a[6:0], 1'b0};
    return {mem[lo_a | 8'h01], mem[lo_a]};
  endfunction

  // Issues one read and counts the cycles ioctl_wait stays high afterwards.
  task automatic run_read(input logic [24:0] a, output int wcyc);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    wcyc = 0;
    while (ioctl_wait === 1'b1 && wcyc < 200) begin
      wcyc++;
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    tests_run++; if (ioctl_din !== 8'h00) begin tests_failed++; $display("FAIL reset_din got %h want 00", ioctl_din); end
    tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    tests_run++; if (ram_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b want 0", ram_req); end
    tests_run++; if (ram_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_addr got %h want 00", ram_addr); end
    tests_run++; if (ram_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rd got %b want 0", ram_rd); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    last_din = 8'h00;
  endtask

  task automatic test_basic_read();
    int w;
    logic [7:0] e;
    gnt_hold = 1'b1;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    @(posedge clk_sys); #1;
    rd_log.delete();
    sb_q.push_back(exp_byte(25'h0));
    run_read(25'h0, w);
    e = sb_q.pop_front();
    last_din = e;
    tests_run++; if (ioctl_din !== e) begin tests_failed++; $display("FAIL basic_din got %h want %h", ioctl_din, e); end
    tests_run++; if (w != 4) begin tests_failed++; $display("FAIL basic_wait_cycles got %0d want 4", w); end
    tests_run++; if (rd_log.size() != 2) begin tests_failed++; $display("FAIL basic_rd_cycles got %0d want 2", rd_log.size()); end
    else begin
      tests_run++; if (rd_log[0] !== 8'h00) begin tests_failed++; $display("FAIL basic_addr_lo got %h want 00", rd_log[0]); end
      tests_run++; if (rd_log[1] !== 8'h01) begin tests_failed++; $display("FAIL basic_addr_hi got %h want 01", rd_log[1]); end
    end
  endtask

  task automatic test_grant_delay();
    int w;
    logic [7:0] e;
    ioctl_upload = 1'b0;
    gnt_hold  = 1'b0;
    gnt_delay = 7;
    repeat (2) begin @(posedge clk_sys); #1; end
    rd_log.delete();
    ioctl_upload = 1'b1;
    sb_q.push_back(exp_byte(25'h7F));
    run_read(25'h7F, w);
    e = sb_q.pop_front();
    last_din = e;
    tests_run++; if (ioctl_din !== e) begin tests_failed++; $display("FAIL gnt_din got %h want %h", ioctl_din, e); end
    tests_run++; if (w != 11) begin tests_failed++; $display("FAIL gnt_wait_cycles got %0d want 11", w); end
    tests_run++; if (rd_log.size() != 2 || rd_log[0] !== 8'hFE || rd_log[1] !== 8'hFF) begin
      tests_failed++; $display("FAIL gnt_rd_addrs got %0d reads want FE,FF", rd_log.size());
    end
    gnt_hold = 1'b1;
  endtask

  task automatic test_out_of_range();
    int w;
    logic [7:0] e;
    @(posedge clk_sys); #1;
    rd_log.delete();
    sb_q.push_back(exp_byte(25'h80));
    run_read(25'h80, w);
    e = sb_q.pop_front();
    last_din = e;
    tests_run++; if (ioctl_din !== e) begin tests_failed++; $display("FAIL oor_din got %h want %h", ioctl_din, e); end
    tests_run++; if (w != 1) begin tests_failed++; $display("FAIL oor_wait_cycles got %0d want 1", w); end
    tests_run++; if (rd_log.size() != 0) begin tests_failed++; $display("FAIL oor_rd_cycles got %0d want 0", rd_log.size()); end
  endtask

  task automatic test_wrong_index();
    int w;
    ioctl_index = 8'd0;
    @(posedge clk_sys); #1;
    run_read(25'h0, w);
    @(posedge clk_sys); #1;
    tests_run++; if (w != 0) begin tests_failed++; $display("FAIL idx_wait_cycles got %0d want 0", w); end
    tests_run++; if (ram_req !== 1'b0) begin tests_failed++; $display("FAIL idx_req got %b want 0", ram_req); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL idx_err got %b want 0", err); end
    tests_run++; if (ioctl_din !== last_din) begin tests_failed++; $display("FAIL idx_din got %h want %h", ioctl_din, last_din); end
    ioctl_index = 8'd4;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] e;
    @(posedge clk_sys); #1;
    sb_q.push_back(exp_byte(25'h0));
    ioctl_addr = 25'h0;
    ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_addr = 25'h1;
    ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 50) begin n++; @(posedge clk_sys); #1; end
    e = sb_q.pop_front();
    last_din = e;
    tests_run++; if (n >= 50) begin tests_failed++; $display("FAIL b2b_timeout got %0d cycles want < 50", n); end
    tests_run++; if (ioctl_din !== e) begin tests_failed++; $display("FAIL b2b_din got %h want %h", ioctl_din, e); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL b2b_err got %b want 1", err); end
    repeat (5) @(posedge clk_sys); #1;
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL b2b_err_sticky got %b want 1", err); end
  endtask

  task automatic test_abort();
    int w;
    logic [7:0] e;
    ioctl_addr = 25'h1;
    ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
    ioctl_upload = 1'b0;
    @(posedge clk_sys); #1;
    tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL abort_wait got %b want 0", ioctl_wait); end
    tests_run++; if (ram_req !== 1'b0) begin tests_failed++; $display("FAIL abort_req got %b want 0", ram_req); end
    tests_run++; if (ram_rd !== 1'b0) begin tests_failed++; $display("FAIL abort_rd got %b want 0", ram_rd); end
    tests_run++; if (ioctl_din !== last_din) begin tests_failed++; $display("FAIL abort_din got %h want %h", ioctl_din, last_din); end
    ioctl_upload = 1'b1;
    repeat (3) begin @(posedge clk_sys); #1; end
    sb_q.push_back(exp_byte(25'h1));
    run_read(25'h1, w);
    e = sb_q.pop_front();
    last_din = e;
    tests_run++; if (ioctl_din !== e || w != 4) begin
      tests_failed++; $display("FAIL abort_recover got %h/%0d want %h/4", ioctl_din, w, e);
    end
  endtask

  task automatic test_reset_mid_read();
    int w;
    logic [7:0] e;
    ioctl_addr = 25'h0;
    ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    #1;
    tests_run++; if (ioctl_din !== 8'h00) begin tests_failed++; $display("FAIL rstmid_din got %h want 00", ioctl_din); end
    tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL rstmid_wait got %b want 0", ioctl_wait); end
    tests_run++; if (ram_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req got %b want 0", ram_req); end
    tests_run++; if (ram_addr !== 8'h00) begin tests_failed++; $display("FAIL rstmid_addr got %h want 00", ram_addr); end
    tests_run++; if (ram_rd !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rd got %b want 0", ram_rd); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err got %b want 0", err); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    sb_q.push_back(exp_byte(25'h0));
    run_read(25'h0, w);
    e = sb_q.pop_front();
    tests_run++; if (ioctl_din !== e || w != 4) begin
      tests_failed++; $display("FAIL rstmid_after got %h/%0d want %h/4", ioctl_din, w, e);
    end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_err_after got %b want 0", err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[8'h00] = 4'h3;
    mem[8'h01] = 4'hA;
    mem[8'h02] = 4'h5;
    mem[8'h03] = 4'hC;
    mem[8'hFE] = 4'h1;
    mem[8'hFF] = 4'h2;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_addr   = 25'h0;
    ioctl_rd     = 1'b0;
    ram_gnt      = 1'b1;

    test_reset();
    test_basic_read();
    test_grant_delay();
    test_out_of_range();
    test_wrong_index();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
